control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 135 +++++++++++++
 tb/tb_control_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle instruction control unit: it accepts an instruction word, decodes it and
// sequences DECODE -> EXEC -> WB while keeping counts of retired and illegal instructions.
module control_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [2:0]            ALUOP,
  output logic [REG_ADDR_W-1:0] READ_REG1,
  output logic [REG_ADDR_W-1:0] READ_REG2,
  output logic [REG_ADDR_W-1:0] WRITE_REG,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic [DATA_WIDTH-1:0] IMMEDIATE,
  output logic                  REG_WRITE_EN,
  output logic                  ILLEGAL,
  output logic [7:0]            RETIRED_CNT,
  output logic [3:0]            ILLEGAL_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;
  typedef enum logic [2:0] {ALU_FWD = 3'b000, ALU_ADD = 3'b001, ALU_AND = 3'b010,
                            ALU_OR  = 3'b011} aluop_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  retired_q, retired_d;
  logic [3:0]  illegal_cnt_q, illegal_cnt_d;

  logic   dec_legal, dec_imm, dec_neg;
  aluop_e dec_aluop;

  // Opcode table, evaluated on the captured word so it stays stable through EXEC and WB.
  always_comb begin
    dec_legal = 1'b1;
    dec_aluop = ALU_FWD;
    dec_imm   = 1'b0;
    dec_neg   = 1'b0;
    case (instr_q[31:24])
      8'h00: dec_imm = 1'b1;
      8'h01: dec_aluop = ALU_FWD;
      8'h02: dec_aluop = ALU_ADD;
      8'h03: begin
        dec_aluop = ALU_ADD;
        dec_neg   = 1'b1;
      end
      8'h04: dec_aluop = ALU_AND;
      8'h05: dec_aluop = ALU_OR;
      default: dec_legal = 1'b0;
    endcase
  end

  // NOTE: every signal written in this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    illegal_cnt_d = illegal_cnt_q;
    INSTR_READY   = 1'b0;
    ALUOP         = ALU_FWD;
    IMM_SEL       = 1'b0;
    NEG_SEL       = 1'b0;
    REG_WRITE_EN  = 1'b0;
    ILLEGAL       = 1'b0;
    case (state_q)
      S_IDLE: begin
        INSTR_READY = 1'b1;
        if (INSTR_VALID) begin
          instr_d = INSTRUCTION;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUOP   = dec_aluop;
        IMM_SEL = dec_imm;
        NEG_SEL = dec_neg;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          ILLEGAL       = 1'b1;
          illegal_cnt_d = (illegal_cnt_q == 4'hF) ? illegal_cnt_q : illegal_cnt_q + 4'd1;
          state_d       = S_IDLE;
        end
      end
      S_EXEC: begin
        ALUOP   = dec_aluop;
        IMM_SEL = dec_imm;
        NEG_SEL = dec_neg;
        state_d = S_WB;
      end
      S_WB: begin
        ALUOP        = dec_aluop;
        IMM_SEL      = dec_imm;
        NEG_SEL      = dec_neg;
        REG_WRITE_EN = 1'b1;
        retired_d    = retired_q + 8'd1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      retired_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Field outputs come straight from the captured word, so they hold between instructions.
  assign READ_REG1   = instr_q[8 +: REG_ADDR_W];
  assign READ_REG2   = instr_q[0 +: REG_ADDR_W];
  assign WRITE_REG   = instr_q[16 +: REG_ADDR_W];
  assign IMMEDIATE   = instr_q[0 +: DATA_WIDTH];
  assign RETIRED_CNT = retired_q;
  assign ILLEGAL_CNT = illegal_cnt_q;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_q[23:19], instr_q[15:11]};

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: the driver predicts each instruction's
// outcome from the opcode table and timing rules, and a monitor checks it on REG_WRITE_EN/ILLEGAL.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  ALUOP;
  logic [2:0]  READ_REG1, READ_REG2, WRITE_REG;
  logic        IMM_SEL, NEG_SEL;
  logic [7:0]  IMMEDIATE;
  logic        REG_WRITE_EN, ILLEGAL;
  logic [7:0]  RETIRED_CNT;
  logic [3:0]  ILLEGAL_CNT;

  control_unit #(.DATA_WIDTH(8), .REG_ADDR_W(3)) dut (
    .CLK(CLK), .RESETN(RESETN), .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .ALUOP(ALUOP), .READ_REG1(READ_REG1), .READ_REG2(READ_REG2),
    .WRITE_REG(WRITE_REG), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL), .IMMEDIATE(IMMEDIATE),
    .REG_WRITE_EN(REG_WRITE_EN), .ILLEGAL(ILLEGAL), .RETIRED_CNT(RETIRED_CNT),
    .ILLEGAL_CNT(ILLEGAL_CNT)
  );

  always #5 CLK = ~CLK;

  // Number of rising edges so far; read at falling edges it names the current cycle.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         illegal;
    int         due;
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic [2:0] rr1, rr2, wr;
    logic [7:0] imm;
    logic [7:0] ret;
    logic [3:0] ill;
  } exp_t;

  exp_t       exp_q[$];
  int         next_free = 0;   // first edge at which the unit can accept again
  logic [7:0] m_ret = 8'd0;
  int         m_ill = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference prediction for a word accepted at edge acc.
  function automatic exp_t predict(input logic [31:0] w, input int acc);
    exp_t e;
    e.illegal = 1'b0;
    e.aluop   = 3'b000;
    e.imm_sel = 1'b0;
    e.neg_sel = 1'b0;
    case (w[31:24])
      8'h00: e.imm_sel = 1'b1;                       // loadi
      8'h01: e.aluop = 3'b000;                       // mov
      8'h02: e.aluop = 3'b001;                       // add
      8'h03: begin e.aluop = 3'b001; e.neg_sel = 1'b1; end  // sub
      8'h04: e.aluop = 3'b010;                       // and
      8'h05: e.aluop = 3'b011;                       // or
      default: e.illegal = 1'b1;
    endcase
    e.rr1 = w[10:8];
    e.rr2 = w[2:0];
    e.wr  = w[18:16];
    e.imm = w[7:0];
    // Illegal pulses in DECODE (cycle after accept); writeback is the third cycle.
    e.due = e.illegal ? acc : acc + 2;
    e.ret = m_ret;
    e.ill = 4'(m_ill);
    return e;
  endfunction

  task automatic issue(input logic [31:0] w);
    bit   done = 1'b0;
    exp_t e;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge CLK);
      if (next_free <= cyc + 1) begin
        check("ready_when_free", INSTR_READY, 1);
        INSTRUCTION = w;
        INSTR_VALID = 1'b1;
        e = predict(w, cyc + 1);
        exp_q.push_back(e);
        if (e.illegal) m_ill = (m_ill < 15) ? m_ill + 1 : 15;
        else           m_ret = m_ret + 8'd1;
        next_free = cyc + 1 + (e.illegal ? 2 : 4);
        done = 1'b1;
      end else begin
        check("ready_when_busy", INSTR_READY, 0);
        INSTRUCTION = $urandom;
        INSTR_VALID = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: word 0x%08h never accepted", w);
    end
  endtask

  task automatic drain();
    @(posedge CLK);
    #1 INSTR_VALID = 1'b0;
    for (int i = 0; i < 16 && (exp_q.size() != 0 || next_free > cyc); i++) begin
      @(posedge CLK);
      #1;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
    end
    check("retired_cnt", RETIRED_CNT, m_ret);
    check("illegal_cnt", ILLEGAL_CNT, m_ill);
  endtask

  // Monitor: compares every writeback/illegal pulse against the next predicted response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESETN !== 1'b1) continue;
      while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event: response due at cycle %0d not seen by cycle %0d",
                 exp_q[0].due, cyc);
        void'(exp_q.pop_front());
      end
      if (REG_WRITE_EN || ILLEGAL) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: wen=%0b illegal=%0b, nothing expected (cycle %0d)",
                   REG_WRITE_EN, ILLEGAL, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.due);
          check("reg_write_en", REG_WRITE_EN, !e.illegal);
          check("illegal", ILLEGAL, e.illegal);
          check("aluop", ALUOP, e.aluop);
          check("imm_sel", IMM_SEL, e.imm_sel);
          check("neg_sel", NEG_SEL, e.neg_sel);
          check("read_reg1", READ_REG1, e.rr1);
          check("read_reg2", READ_REG2, e.rr2);
          check("write_reg", WRITE_REG, e.wr);
          check("immediate", IMMEDIATE, e.imm);
          check("retired_before", RETIRED_CNT, e.ret);
          check("illegal_before", ILLEGAL_CNT, e.ill);
        end
      end else if (INSTR_READY) begin
        check("idle_ctrl", {ALUOP, IMM_SEL, NEG_SEL}, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] op;
    RESETN      = 1'b0;
    INSTR_VALID = 1'b0;
    INSTRUCTION = 32'h0;
    #1;
    check("reset_ready", INSTR_READY, 1);
    check("reset_outputs", {ALUOP, READ_REG1, READ_REG2, WRITE_REG, IMM_SEL, NEG_SEL,
                            IMMEDIATE, REG_WRITE_EN, ILLEGAL}, 0);
    check("reset_counts", {RETIRED_CNT, ILLEGAL_CNT}, 0);
    repeat (2) @(posedge CLK);
    #2 RESETN = 1'b1;

    // Directed: loadi, sub, one illegal opcode.
    issue(32'h0003_0005);
    drain();
    issue(32'h0302_0104);
    drain();
    issue(32'h0700_1234);
    drain();

    // add / and / or back to back with INSTR_VALID held high.
    issue(32'h0205_0306);
    issue(32'h0401_0702);
    issue(32'h0506_0203);
    drain();

    // Reset asserted while an add is in EXEC: no writeback, everything back to zero.
    issue(32'h0207_0605);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESETN = 1'b0;
    INSTR_VALID = 1'b0;
    #1;
    check("midreset_ready", INSTR_READY, 1);
    check("midreset_outputs", {ALUOP, READ_REG1, READ_REG2, WRITE_REG, IMM_SEL, NEG_SEL,
                               IMMEDIATE, REG_WRITE_EN, ILLEGAL}, 0);
    check("midreset_counts", {RETIRED_CNT, ILLEGAL_CNT}, 0);
    exp_q.delete();
    next_free = 0;
    m_ret     = 8'd0;
    m_ill     = 0;
    @(posedge CLK);
    #2 RESETN = 1'b1;
    issue(32'h0304_0201);
    drain();

    // Twenty illegal opcodes saturate ILLEGAL_CNT at 15.
    for (int i = 0; i < 20; i++) begin
      op = 8'($urandom_range(6, 255));
      issue({op, 24'($urandom)});
    end
    drain();

    // Random mix with idle gaps; over 256 legal instructions so RETIRED_CNT wraps.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        INSTRUCTION = $urandom;
      end
      op = (i % 8 == 7) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(0, 5));
      issue({op, 24'($urandom)});
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
